// File: rtl/pos_cell_reader_if.sv
// Output beat stream of pos_cell_reader: one particle position per accepted beat.
interface pos_cell_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_pid;
  logic                  out_last;

  modport master (output out_valid, output out_data, output out_pid, output out_last,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_pid, input  out_last,
                  output out_ready);
endinterface

// File: rtl/pos_cell_reader.sv
// Streams one position cell (address 0 = count, 1..count = particles) out over valid/ready,
// issuing 2-cycle-latency RAM reads only when the output FIFO is guaranteed to have room.
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  pos_cell_reader_if.master     beat
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, DONE} state_t;
  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] next_addr, next_addr_d, issue_addr, rd_addr_q;
  logic [ADDR_WIDTH-1:0] count_raw, count_clamped;
  logic                  issue, issue_cnt;

  // in-flight tracker: valid, count-read tag and address per RAM pipeline stage
  logic                  v1, v2, c1, c2;
  logic [ADDR_WIDTH-1:0] a1, a2;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pid  [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           occ;
  logic                  push, pop, credit_ok, count_ret;
  logic [CW-1:0]         credit_sum;

  assign count_raw     = rd_data[ADDR_WIDTH-1:0];
  assign count_clamped = (count_raw > MAX_COUNT) ? MAX_COUNT : count_raw;
  assign count_ret     = v2 && c2;
  assign push          = v2 && !c2;
  assign pop           = beat.out_valid && beat.out_ready;

  // occupancy is taken after this cycle's pop so a stalled-then-released consumer frees credit at once
  assign credit_sum = CW'(occ) - CW'(pop) + CW'(v1) + CW'(v2);
  assign credit_ok  = credit_sum < CW'(FIFO_DEPTH);

  always_comb begin
    state_d     = state;
    next_addr_d = next_addr;
    issue       = 1'b0;
    issue_cnt   = 1'b0;
    issue_addr  = next_addr;
    unique case (state)
      IDLE:    if (start) state_d = CNT_REQ;
      CNT_REQ: begin
        issue      = 1'b1;
        issue_cnt  = 1'b1;
        issue_addr = '0;
        state_d    = CNT_WAIT;
      end
      CNT_WAIT: if (count_ret) begin
        next_addr_d = ADDR_WIDTH'(1);
        state_d     = (count_clamped == '0) ? DONE : STREAM;
      end
      STREAM: if (credit_ok) begin
        issue       = 1'b1;
        next_addr_d = next_addr + ADDR_WIDTH'(1);
        if (next_addr == particle_count) state_d = DRAIN;
      end
      DRAIN: if (!v1 && !v2 && (occ == '0 || (occ == (PW+1)'(1) && pop))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_en   = issue;
  assign rd_addr = issue ? issue_addr : rd_addr_q;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      next_addr      <= '0;
      rd_addr_q      <= '0;
      particle_count <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      c1 <= 1'b0;
      c2 <= 1'b0;
      a1 <= '0;
      a2 <= '0;
    end else begin
      state     <= state_d;
      next_addr <= next_addr_d;
      if (issue) rd_addr_q <= issue_addr;
      if (state == CNT_WAIT && count_ret) particle_count <= count_clamped;
      v1 <= issue;
      c1 <= issue_cnt;
      a1 <= issue_addr;
      v2 <= v1;
      c2 <= c1;
      a2 <= a1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_pid[wr_ptr]  <= a2;
      fifo_last[wr_ptr] <= (a2 == particle_count);
    end
  end

  // storage is not reset, so the payload is forced to zero whenever nothing is buffered
  assign beat.out_valid = (occ != '0);
  assign beat.out_data  = beat.out_valid ? fifo_data[rd_ptr] : '0;
  assign beat.out_pid   = beat.out_valid ? fifo_pid[rd_ptr]  : '0;
  assign beat.out_last  = beat.out_valid && fifo_last[rd_ptr];

endmodule
